// File: rtl/instruction_dispatcher.sv
// rtl/instruction_dispatcher.sv - buffers upstream instructions and issues them one at a time to the Processor.
// Optional WAIT-state watchdog enabled with `define DISPATCHER_TIMEOUT_EN.

package Isa;
  typedef enum logic [3:0] {
    NOOP  = 4'd0,
    ADD   = 4'd1,
    SUB   = 4'd2,
    AND   = 4'd3,
    OR    = 4'd4,
    XOR   = 4'd5,
    LOAD  = 4'd6,
    STORE = 4'd7
  } OpCode;

  typedef struct packed {
    OpCode      op_code;
    logic [9:0] rd;
    logic [9:0] rs_1;
    logic [9:0] rs_2;
  } Instruction;
endpackage

module instruction_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  Isa::Instruction               i_instruction,
  output logic                          o_ready,
  output Isa::Instruction               o_instruction,
  output logic                          o_start,
  input  logic                          i_done,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic [15:0]                   o_issued,
  output logic                          o_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("instruction_dispatcher: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  Isa::Instruction  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t           r_state;
  state_t           w_state_nxt;
  Isa::Instruction  r_instruction;
  logic             r_start;
  logic [15:0]      r_issued;
  logic             r_timeout;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic             w_complete;
  logic             w_expire;
  Isa::Instruction  w_head;

  // Readiness depends on occupancy only, so a pop never frees a slot for a same-cycle push.
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_instruction;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef DISPATCHER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] r_timer;

  assign w_expire = (r_state == S_WAIT) && !i_done && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_issue) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT && !i_done) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_expire  = 1'b0;
  assign r_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // NOOP words are popped and dropped without leaving IDLE.
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head != '0) begin
            w_issue     = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_done) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_instruction <= '0;
      r_start       <= 1'b0;
      r_issued      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_issue;
      if (w_issue) begin
        r_instruction <= w_head;
      end else if (w_expire) begin
        r_instruction <= '0;
      end
      if (w_complete) begin
        r_issued <= r_issued + 16'd1;
      end
    end
  end

  assign o_ready       = !w_full;
  assign o_count       = r_count;
  assign o_instruction = r_instruction;
  assign o_start       = r_start;
  assign o_busy        = (r_state == S_WAIT);
  assign o_issued      = r_issued;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// tb/tb_instruction_dispatcher.sv - directed bench with a queue-based reference model for instruction_dispatcher.
module tb_instruction_dispatcher;
  import Isa::*;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       done = 1'b0;
  Instruction instr = '0;
  logic       o_ready;
  Instruction o_instruction;
  logic       o_start;
  logic       o_busy;
  logic [2:0] o_count;
  logic [15:0] o_issued;
  logic       o_timeout;

  always #5 clk = ~clk;

  instruction_dispatcher #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_instruction(instr),
    .o_ready(o_ready), .o_instruction(o_instruction), .o_start(o_start),
    .i_done(done), .o_busy(o_busy), .o_count(o_count), .o_issued(o_issued),
    .o_timeout(o_timeout)
  );

  // Reference model: buffered words, current issued word, outstanding flag.
  Instruction mq[$];
  Instruction m_cur;
  bit         m_busy, m_start, m_timeout;
  int         m_issued, m_wait;
  Instruction log_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic Instruction mk(OpCode op, int rd, int a, int b);
    Instruction r;
    r.op_code = op;
    r.rd      = rd[9:0];
    r.rs_1    = a[9:0];
    r.rs_2    = b[9:0];
    return r;
  endfunction

  task automatic check1(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cur = '0; m_busy = 0; m_start = 0; m_timeout = 0; m_issued = 0; m_wait = 0;
  endtask

  task automatic model_edge(bit v, Instruction w, bit d);
    bit acc;
    Instruction h;
    acc = v && (mq.size() < DEPTH);
    m_start = 0;
    if (m_busy) begin
      if (d) begin
        m_busy = 0;
        m_issued = (m_issued + 1) & 16'hFFFF;
      end
`ifdef DISPATCHER_TIMEOUT_EN
      else if (m_wait == TO - 1) begin
        m_busy = 0; m_timeout = 1; m_cur = '0;
      end else m_wait++;
`endif
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (h != '0) begin
        m_cur = h; m_start = 1; m_busy = 1; m_wait = 0;
      end
    end
    if (acc) mq.push_back(w);
  endtask

  task automatic compare_all();
    check1("o_ready", 64'(o_ready), 64'(mq.size() < DEPTH));
    check1("o_count", 64'(o_count), 64'(mq.size()));
    check1("o_instruction", 64'(o_instruction), 64'(m_cur));
    check1("o_start", 64'(o_start), 64'(m_start));
    check1("o_busy", 64'(o_busy), 64'(m_busy));
    check1("o_issued", 64'(o_issued), 64'(m_issued));
    check1("o_timeout", 64'(o_timeout), 64'(m_timeout));
    if (o_start) log_q.push_back(o_instruction);
  endtask

  task automatic step(bit v, Instruction w, bit d);
    valid = v; instr = w; done = d;
    @(posedge clk);
    model_edge(v, w, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    valid = 0; instr = '0; done = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    log_q.delete();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Instruction w, wa, wb;
    Instruction words[14];
    int p, busy_cnt;
    bit acc, saw_zero;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Reset then idle
    for (int i = 0; i < 20; i++) step(0, '0, 0);
    check1("idle_no_start", 64'(log_q.size()), 64'd0);
    check1("idle_ready", 64'(o_ready), 64'd1);

    // Single issue: one-cycle latency after the push edge
    w = mk(ADD, 995, 996, 998);
    step(1, w, 0);
    check1("single_start_lat0", 64'(o_start), 64'd0);
    check1("single_count", 64'(o_count), 64'd1);
    step(0, '0, 0);
    check1("single_start", 64'(o_start), 64'd1);
    check1("single_instr", 64'(o_instruction), 64'(w));
    check1("single_busy", 64'(o_busy), 64'd1);
    step(0, '0, 0);
    step(0, '0, 1);
    check1("single_busy_done", 64'(o_busy), 64'd0);
    check1("single_issued", 64'(o_issued), 64'd1);
    check1("single_instr_hold", 64'(o_instruction), 64'(w));

    // NOOP filtering
    do_reset();
    wa = mk(OR, 1022, 1019, 1018);
    wb = mk(AND, 1023, 1023, 1023);
    step(1, '0, 0);
    step(1, wa, 0);
    step(1, '0, m_busy);
    step(1, wb, m_busy);
    for (int i = 0; i < 10; i++) step(0, '0, m_busy);
    check1("noop_starts", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check1("noop_first", 64'(log_q[0]), 64'(wa));
      check1("noop_second", 64'(log_q[1]), 64'(wb));
    end
    check1("noop_issued", 64'(o_issued), 64'd2);

    // Full FIFO and pointer wrap
    do_reset();
    for (int i = 0; i < 14; i++) words[i] = mk(OpCode'(4'(1 + i % 7)), i * 37 + 1, i + 100, 1000 - i);
    for (int i = 0; i < 5; i++) step(1, words[i], 0);
    check1("full_count", 64'(o_count), 64'd4);
    check1("full_ready", 64'(o_ready), 64'd0);
    check1("full_issued_one", 64'(log_q.size()), 64'd1);
    step(1, words[5], 0);
    check1("full_refused_count", 64'(o_count), 64'd4);
    p = 5;
    for (int cyc = 0; cyc < 400 && log_q.size() < 14; cyc++) begin
      acc = (p < 14) && (mq.size() < DEPTH);
      step(p < 14, (p < 14) ? words[p] : Instruction'('0), m_busy && (cyc % 2 == 0));
      if (acc) p++;
    end
    check1("wrap_all_issued", 64'(log_q.size()), 64'd14);
    for (int i = 0; i < 14 && i < log_q.size(); i++) check1($sformatf("wrap_order_%0d", i), 64'(log_q[i]), 64'(words[i]));
    step(0, '0, 1);
    step(0, '0, 0);
    check1("wrap_issued", 64'(o_issued), 64'd14);

    // Reset during WAIT with three words buffered
    do_reset();
    for (int i = 0; i < 4; i++) step(1, words[i], 0);
    check1("midrst_count_pre", 64'(o_count), 64'd3);
    check1("midrst_busy_pre", 64'(o_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("midrst_ready", 64'(o_ready), 64'd1);
    check1("midrst_count", 64'(o_count), 64'd0);
    check1("midrst_instr", 64'(o_instruction), 64'd0);
    check1("midrst_start", 64'(o_start), 64'd0);
    check1("midrst_busy", 64'(o_busy), 64'd0);
    check1("midrst_issued", 64'(o_issued), 64'd0);
    model_reset();
    log_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(0, '0, 0);
    check1("midrst_no_start", 64'(log_q.size()), 64'd0);

    // WAIT watchdog
    do_reset();
    wa = mk(SUB, 5, 6, 7);
    wb = mk(XOR, 8, 9, 10);
`ifdef DISPATCHER_TIMEOUT_EN
    busy_cnt = 0;
    saw_zero = 0;
    step(1, wa, 0);
    step(1, wb, 0);
    for (int cyc = 0; cyc < 40 && log_q.size() < 2; cyc++) begin
      if (o_busy && log_q.size() == 1) busy_cnt++;
      step(0, '0, 0);
      if (o_timeout && o_instruction == '0 && !o_busy) saw_zero = 1;
    end
    check1("to_wait_cycles", 64'(busy_cnt), 64'(TO));
    check1("to_saw_cleared_instr", 64'(saw_zero), 64'd1);
    check1("to_next_issued", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) check1("to_next_word", 64'(log_q[1]), 64'(wb));
    step(0, '0, 1);
    step(0, '0, 0);
    check1("to_sticky", 64'(o_timeout), 64'd1);
    check1("to_issued", 64'(o_issued), 64'd1);
`else
    busy_cnt = 0;
    saw_zero = 0;
    step(1, wa, 0);
    for (int cyc = 0; cyc < 30; cyc++) begin
      step(0, '0, 0);
      if (o_busy) busy_cnt++;
    end
    check1("nto_wait_forever", 64'(busy_cnt), 64'd30);
    check1("nto_timeout_zero", 64'(o_timeout), 64'd0);
    check1("nto_instr_held", 64'(o_instruction), 64'(wa));
    step(0, '0, 1);
    check1("nto_issued", 64'(o_issued), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_dispatcher.md
# instruction_dispatcher

Sequencer in front of the `Processor` datapath. It buffers instructions from an upstream source over a valid/ready handshake and issues them one at a time on the processor's instruction input. It waits for writeback completion before each issue and drops all-zero NOOP words without issuing them. The upstream source no longer has to track processor state (e.g. wait for STORE) itself.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 64: WAIT-state cycle limit; used only with `DISPATCHER_TIMEOUT_EN`.

Ports:
- `i_clock`  in  1: single clock; all logic on the rising edge.
- `i_reset`  in  1: asynchronous, active-low reset.
- `i_valid`  in  1: upstream instruction valid.
- `i_instruction`  in  `Isa::Instruction`: upstream instruction {op_code, rd, rs_1, rs_2}.
- `o_ready`  out  1: buffer can accept a word; equals `!full`.
- `o_instruction`  out  `Isa::Instruction`: drives the processor `i_instruction`; registered.
- `o_start`  out  1: one-cycle pulse, first cycle of a new `o_instruction`.
- `i_done`  in  1: processor pulse, register writeback complete.
- `o_busy`  out  1: high in WAIT.
- `o_count`  out  `$clog2(FIFO_DEPTH)+1`: buffer occupancy.
- `o_issued`  out  16: wrapping count of completed (non-NOOP) instructions.
- `o_timeout`  out  1: sticky timeout flag; constant 0 without `DISPATCHER_TIMEOUT_EN`.

## Operation
- Circular FIFO with read/write pointers and a count.
- Push happens when `i_valid && o_ready`.
- Pop is performed by the FSM only.
- States: IDLE, WAIT.
- IDLE, FIFO empty: hold.
- IDLE, head is all-zero: pop and discard. No `o_start`, `o_instruction` unchanged, `o_issued` unchanged. Stay in IDLE.
- IDLE, head is non-zero: pop, register the head into `o_instruction`, assert `o_start` for one cycle, go to WAIT.
- WAIT: `o_instruction` is held stable. On `i_done`=1, `o_issued`+1 (wraps 0xFFFF→0) and go to IDLE.
- `i_done` seen in IDLE is ignored.
- Full FIFO: `o_ready`=0. A push is refused even when a pop happens in the same cycle, so `o_ready` has no combinational path from the FSM.
- Empty FIFO with a simultaneous push: the word is not visible to the FSM until the next cycle.
- Pointer wrap is modulo `FIFO_DEPTH`. `o_count` ranges over 0..`FIFO_DEPTH`.

## Timing
- Reset values, all asynchronous on `i_reset`=0:
  - FSM in IDLE, FIFO emptied, `o_count`=0, `o_ready`=1.
  - `o_instruction`=0 (NOOP), `o_start`=0, `o_busy`=0, `o_issued`=0, `o_timeout`=0.
- Reset mid-WAIT abandons the instruction. No completion is counted.
- Push at edge k into an empty FIFO with FSM in IDLE: `o_instruction`/`o_start` are valid from edge k+1. Latency is 1 cycle.
- `i_done` sampled high at edge d (in WAIT): IDLE from d. The next issue comes at edge d+1 at the earliest.
- Throughput: one instruction per (processor latency + 1) cycles.
- NOOP drop costs 1 IDLE cycle per NOOP.
- `i_done` may be high during the `o_start` cycle. It is accepted, giving a minimum WAIT of 1 cycle.
- `o_busy` is high for exactly the WAIT cycles.

## Configuration
- `DISPATCHER_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle without `i_done`.
  - When it reaches `TIMEOUT_CYCLES`: set `o_timeout` (sticky until reset), load `o_instruction`=0, go to IDLE, leave `o_issued` unchanged.
  - `i_done` in the same cycle as expiry wins: normal completion, no timeout.
- `DISPATCHER_TIMEOUT_EN` not defined: no counter, WAIT lasts indefinitely, `o_timeout` is tied to 0.

## Test plan
- Reset then idle: after `i_reset` releases, expect `o_ready`=1, `o_count`=0, `o_instruction`=0, no `o_start` for 20 cycles.
- Single issue: push {ADD,995,996,998}. Expect `o_start` one cycle later with the same word, `o_busy`=1. Pulse `i_done` 3 cycles later. Expect `o_busy`=0 and `o_issued`=1.
- NOOP filtering: push 0, {OR,1022,1019,1018}, 0, {AND,1023,1023,1023}. Expect exactly 2 `o_start` pulses, in order, and `o_issued`=2 after two `i_done` pulses.
- Full/wrap: hold `i_done`=0 and push 5 non-NOOP words with DEPTH=4. Expect 1 issued and `o_count`=4, then `o_ready`=0 with the 6th word refused. Drain with `i_done` pulses for 3 full pointer laps (12+ words). Expect order preserved.
- Reset mid-operation: reset asserted during WAIT with `o_count`=3. Expect all outputs at reset values immediately and no further `o_start` without new pushes.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): issue one word and never pulse `i_done`. After 8 WAIT cycles expect `o_timeout`=1, `o_instruction`=0, `o_issued`=0, and the next buffered word issued. `o_timeout` stays at 1.
